// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer
//   Accepts one ALU command at a time, drives the registered opcode/operands
//   to an external ALU, waits ALU_LATENCY edges, then captures Alu_out and
//   presents it as a response held until the consumer takes it. Illegal
//   opcodes (4..7) are answered immediately with rsp_err=1 and rsp_data=0.
//
// Parameters
//   DATA_WIDTH   operand/result width in bits
//   ALU_LATENCY  edges from ALU input change to valid Alu_out (0..15)
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_opcode, cmd_a, cmd_b         command fields
//   opcode, A_in, B_in               registered ALU inputs
//   Alu_out                          ALU result
//   rsp_valid/rsp_ready              response handshake
//   rsp_data, rsp_err, rsp_mismatch  response fields
//
// Build option
//   ALU_ISSUER_CHECK_EN  compiles in a reference model; rsp_mismatch flags a
//                        captured result that disagrees with it. When not
//                        defined, rsp_mismatch is tied to 0.
module alu_cmd_issuer #(
  parameter int unsigned DATA_WIDTH  = 1024,
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_opcode,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  output logic [2:0]            opcode,
  output logic [DATA_WIDTH-1:0] A_in,
  output logic [DATA_WIDTH-1:0] B_in,
  input  logic [DATA_WIDTH-1:0] Alu_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  rsp_mismatch
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef enum logic [2:0] {
    OP_PARITY   = 3'd0,
    OP_POPCOUNT = 3'd1,
    OP_ROTR     = 3'd2,
    OP_ROTL     = 3'd3
  } op_e;

  state_e     state, state_next;
  logic [3:0] lat_cnt;
  logic       accept;
  logic       legal_op;
  logic       do_capture;
  logic       rsp_hs;

  // Gated by rst so the port reads 0 while reset is held, yet is high in the
  // very first cycle after release.
  assign cmd_ready  = (state == IDLE) && !rst;
  assign accept     = cmd_valid && cmd_ready;
  assign legal_op   = ~cmd_opcode[2];
  assign do_capture = (state == WAIT) && (lat_cnt == 4'd0);
  assign rsp_hs     = (state == RESP) && rsp_ready;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = legal_op ? WAIT : RESP;
      WAIT: if (lat_cnt == 4'd0) state_next = RESP;
      RESP: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      opcode    <= '0;
      A_in      <= '0;
      B_in      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        if (legal_op) begin
          opcode  <= cmd_opcode;
          A_in    <= cmd_a;
          B_in    <= cmd_b;
          lat_cnt <= 4'(ALU_LATENCY);
        end else begin
          rsp_data  <= '0;
          rsp_err   <= 1'b1;
          rsp_valid <= 1'b1;
        end
      end
      if (state == WAIT) begin
        if (lat_cnt == 4'd0) begin
          rsp_data  <= Alu_out;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
        end else begin
          lat_cnt <= lat_cnt - 4'd1;
        end
      end
      if (rsp_hs) begin
        rsp_valid <= 1'b0;
        rsp_err   <= 1'b0;
      end
    end
  end

`ifdef ALU_ISSUER_CHECK_EN
  localparam int unsigned SHW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] expected;

  // Operands are held in A_in/B_in for the whole WAIT phase, so the model
  // can work from them directly at capture time.
  always_comb begin
    int unsigned sh;
    int unsigned cnt;
    expected = '0;
    sh       = 32'(B_in[SHW-1:0]);
    cnt      = 0;
    case (op_e'(opcode))
      OP_PARITY: expected[0] = ^A_in;
      OP_POPCOUNT: begin
        for (int unsigned i = 0; i < DATA_WIDTH; i++) cnt = cnt + 32'(A_in[i]);
        expected = DATA_WIDTH'(cnt);
      end
      OP_ROTR: expected = (A_in >> sh) | (A_in << (DATA_WIDTH - sh));
      OP_ROTL: expected = (A_in << sh) | (A_in >> (DATA_WIDTH - sh));
      default: expected = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_mismatch <= 1'b0;
    end else if (do_capture) begin
      rsp_mismatch <= (Alu_out != expected);
    end else if (rsp_hs) begin
      rsp_mismatch <= 1'b0;
    end
  end
`else
  assign rsp_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
module tb_alu_cmd_issuer;

  localparam int unsigned DW  = 16;
  localparam int unsigned LAT = 1;
`ifdef ALU_ISSUER_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_opcode;
  logic [DW-1:0] cmd_a, cmd_b;
  logic [2:0]    opcode;
  logic [DW-1:0] A_in, B_in;
  logic [DW-1:0] Alu_out;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          rsp_mismatch;
  logic          alu_bad;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.DATA_WIDTH(DW), .ALU_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .opcode(opcode), .A_in(A_in), .B_in(B_in), .Alu_out(Alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_mismatch(rsp_mismatch)
  );

  // External ALU stub: one register stage, optionally returning unrotated A.
  function automatic logic [DW-1:0] alu_fn(input logic [2:0] op,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    logic [3:0] s;
    s = b[3:0];
    case (op)
      3'd0: alu_fn = {{(DW-1){1'b0}}, ^a};
      3'd1: alu_fn = DW'($countones(a));
      3'd2: alu_fn = (a >> s) | (a << (16 - s));
      3'd3: alu_fn = (a << s) | (a >> (16 - s));
      default: alu_fn = '0;
    endcase
  endfunction

  always @(posedge clk) Alu_out <= alu_bad ? A_in : alu_fn(opcode, A_in, B_in);

  typedef struct packed {
    logic [DW-1:0] d;
    logic          e;
    logic          m;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  logic [2:0]  last_op;
  logic [DW-1:0] last_a, last_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a response is taken at the edge following a negedge where
  // rsp_valid && rsp_ready, so each response is popped exactly once.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got data 0x%0h with empty queue", rsp_data);
      end else begin
        e = q.pop_front();
        chk("rsp_data", 32'(rsp_data), 32'(e.d));
        chk("rsp_err", 32'(rsp_err), 32'(e.e));
        chk("rsp_mismatch", 32'(rsp_mismatch), 32'(e.m));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
  endtask

  // Called at a negedge; returns at the negedge where rsp_valid is first seen.
  task automatic issue(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] exp_d, input logic exp_e, input logic exp_m);
    int cyc = 0;
    wait_ready();
    q.push_back('{d: exp_d, e: exp_e, m: exp_m});
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    if (exp_e) begin
      chk("opcode_kept", 32'(opcode), 32'(last_op));
      chk("A_in_kept", 32'(A_in), 32'(last_a));
      chk("B_in_kept", 32'(B_in), 32'(last_b));
    end else begin
      chk("opcode_load", 32'(opcode), 32'(op));
      chk("A_in_load", 32'(A_in), 32'(a));
      chk("B_in_load", 32'(B_in), 32'(b));
      last_op = op;
      last_a  = a;
      last_b  = b;
    end
    while (!rsp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("rsp_latency", 32'(cyc), exp_e ? 32'd0 : 32'(LAT + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0;
    rsp_ready = 1'b1; alu_bad = 1'b0;
    last_op = '0; last_a = '0; last_b = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_mismatch", 32'(rsp_mismatch), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_A_in", 32'(A_in), 32'd0);
    chk("rst_B_in", 32'(B_in), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    // Directed vectors, expected values worked by hand.
    issue(3'd0, 16'h00AC, 16'h00AC, 16'h0000, 1'b0, 1'b0); // parity of 4 ones
    issue(3'd1, 16'h00ED, 16'h0000, 16'h0006, 1'b0, 1'b0); // popcount
    issue(3'd0, 16'h00AD, 16'h0000, 16'h0001, 1'b0, 1'b0); // parity of 5 ones
    issue(3'd2, 16'h00AD, 16'h0003, 16'hA015, 1'b0, 1'b0); // rotr 3
    issue(3'd2, 16'h00AD, 16'h0013, 16'hA015, 1'b0, 1'b0); // only B[3:0] used
    issue(3'd3, 16'h00AD, 16'h0004, 16'h0AD0, 1'b0, 1'b0); // rotl 4
    issue(3'd3, 16'h8001, 16'h0001, 16'h0003, 1'b0, 1'b0); // rotl wraps MSB
    issue(3'd2, 16'h0001, 16'h000F, 16'h0002, 1'b0, 1'b0); // rotr 15
    issue(3'd2, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0); // rotr 0
    issue(3'd1, 16'hFFFF, 16'h0000, 16'h0010, 1'b0, 1'b0); // popcount full
    issue(3'd5, 16'h5555, 16'h6666, 16'h0000, 1'b1, 1'b0); // illegal
    issue(3'd7, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0); // illegal

    // Back-pressure: response must hold, command ignored.
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    issue(3'd1, 16'h000F, 16'h0000, 16'h0004, 1'b0, 1'b0);
    cmd_valid = 1'b1; cmd_opcode = 3'd6; cmd_a = 16'hFFFF; cmd_b = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_data", 32'(rsp_data), 32'd4);
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    chk("hold_opcode", 32'(opcode), 32'd1);
    chk("hold_A_in", 32'(A_in), 32'h000F);
    chk("hold_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ready_after_hs", 32'(cmd_ready), 32'd1);
    chk("valid_after_hs", 32'(rsp_valid), 32'd0);

    // Reset pulse while the operation is in WAIT.
    wait_ready();
    cmd_valid = 1'b1; cmd_opcode = 3'd0; cmd_a = 16'h00FF; cmd_b = 16'h0000;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("wrst_opcode", 32'(opcode), 32'd0);
    chk("wrst_A_in", 32'(A_in), 32'd0);
    chk("wrst_B_in", 32'(B_in), 32'd0);
    chk("wrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("wrst_rsp_data", 32'(rsp_data), 32'd0);
    chk("wrst_rsp_err", 32'(rsp_err), 32'd0);
    chk("wrst_cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    last_op = '0; last_a = '0; last_b = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("wrst_ready", 32'(cmd_ready), 32'd1);

    // Self-check model: wrong ALU result, then correct one.
    alu_bad = 1'b1;
    issue(3'd2, 16'h00AD, 16'h0003, 16'h00AD, 1'b0, CHK);
    alu_bad = 1'b0;
    issue(3'd2, 16'h00AD, 16'h0003, 16'hA015, 1'b0, 1'b0);

    for (int n = 0; n < 20 && q.size() != 0; n++) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
